// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter; store-to-start-bit latency 1 clock, frames contiguous.
// Stores to a full FIFO are dropped and flagged in sticky STATUS.overflow unless a pop frees a slot on that edge.
module mmio_uart_tx #(
    parameter int                   BUS_WIDTH   = 32,
    parameter logic [BUS_WIDTH-1:0] BASE_ADDR   = 'h0000_1000,
    parameter int                   FIFO_DEPTH  = 4,
    parameter logic [15:0]          DEFAULT_DIV = 16'd3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] addr,
    input  logic                 wr,
    input  logic [BUS_WIDTH-1:0] wdata,
    output logic [BUS_WIDTH-1:0] rdata,
    output logic                 tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q;
    logic [15:0]   bitcnt_q;
    logic [2:0]    bitidx_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   baud_q, baud_d;

    logic          sel;
    logic [1:0]    off;
    logic          push_req, push_ok, pop, bit_end;
    logic          full, empty, busy;
    logic [4:0]    cnt5;
    logic [7:0]    head;
    logic          unused_bits;

    assign sel      = (addr[BUS_WIDTH-1:4] == BASE_ADDR[BUS_WIDTH-1:4]);
    assign off      = addr[3:2];
    assign bit_end  = (bitcnt_q == 16'd0);
    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign empty    = (cnt_q == '0);
    assign busy     = (state_q != IDLE);
    assign cnt5     = 5'(cnt_q);
    assign head     = fifo_q[rd_ptr_q];
    assign tx       = tx_q;

    // The FSM takes the head either from IDLE or at the end of a stop bit.
    assign pop      = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
    assign push_req = wr && sel && (off == 2'd0);
    assign push_ok  = push_req && (!full || pop);

    assign unused_bits = &{1'b0, addr[1:0], wdata[BUS_WIDTH-1:16]};

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q;
        if (push_req && !push_ok)
            ovf_d = 1'b1;
        else if (wr && sel && off == 2'd1 && wdata[3])
            ovf_d = 1'b0;
        baud_d = (wr && sel && off == 2'd2) ? wdata[15:0] : baud_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            baud_q   <= DEFAULT_DIV;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            baud_q   <= baud_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_q[wr_ptr_q] <= wdata[7:0];
    end

    // tx_q is loaded with the level of the bit being entered, so the line is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            bitidx_q <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q  <= head;
                        bitcnt_q <= baud_q;
                        state_q  <= START;
                        tx_q     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bitcnt_q <= baud_q;
                        bitidx_q <= 3'd0;
                        state_q  <= DATA;
                        tx_q     <= shift_q[0];
                    end else begin
                        bitcnt_q <= bitcnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bitcnt_q <= baud_q;
                        if (bitidx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q  <= shift_q >> 1;
                            bitidx_q <= bitidx_q + 1'b1;
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        bitcnt_q <= bitcnt_q - 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bitcnt_q <= baud_q;
                        if (pop) begin
                            shift_q <= head;
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        bitcnt_q <= bitcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                2'd1: begin
                    rdata[0]   = full;
                    rdata[1]   = empty;
                    rdata[2]   = busy;
                    rdata[3]   = ovf_q;
                    rdata[8:4] = cnt5;
                end
                2'd2:    rdata[15:0] = baud_q;
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: the expected serial line is built from whole frames
// (start, eight LSB-first data bits, stop) and compared against a per-cycle log of tx.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] TXD    = BASE;
    localparam logic [31:0] STAT   = BASE + 32'h4;
    localparam logic [31:0] BAUD   = BASE + 32'h8;
    localparam logic [31:0] RSVD   = BASE + 32'hC;
    localparam int          LOG    = 8192;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr  = '0;
    logic        wr    = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic txlog [LOG];
    logic expq [$];

    mmio_uart_tx #(
        .BUS_WIDTH  (32),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .DEFAULT_DIV(16'd3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .wr   (wr),
        .wdata(wdata),
        .rdata(rdata),
        .tx   (tx)
    );

    always #5 clk = ~clk;

    // txlog[k] holds the line level just after rising edge k.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (cyc < LOG) txlog[cyc] = tx;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached without finishing", $time);
        $fatal(1, "watchdog");
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d, output int edge_cyc);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        edge_cyc = cyc;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d    = rdata;
        addr = '0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add_bits(input logic level, input int n);
        repeat (n) expq.push_back(level);
    endtask

    task automatic add_frame(input logic [7:0] b, input int div);
        add_bits(1'b0, div + 1);
        for (int i = 0; i < 8; i++) add_bits(b[i], div + 1);
        add_bits(1'b1, div + 1);
    endtask

    function automatic logic [31:0] rnd_hi(input logic [7:0] b);
        logic [31:0] r;
        r = $urandom;
        return {r[31:8], b};
    endfunction

    task automatic test_reset;
        logic [31:0] d;
        #1 reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: tx=%b expected 1", tx); end
        rd(STAT, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL reset_status: got %h expected %h", d, 32'h2); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        rd(STAT, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL release_status: got %h expected %h", d, 32'h2); end
        rd(BAUD, d);
        checks++;
        if (d !== 32'h3) begin failures++; $display("FAIL release_baud: got %h expected %h", d, 32'h3); end
        rd(TXD, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL txdata_read: got %h expected 0", d); end
    endtask

    task automatic test_single;
        int n0;
        logic [31:0] d;
        store(TXD, rnd_hi(8'hA5), n0);
        rd(STAT, d);
        checks++;
        if (d !== 32'h10) begin failures++; $display("FAIL single_stat_queued: got %h expected %h", d, 32'h10); end
        wait_until(n0 + 1);
        rd(STAT, d);
        checks++;
        if (d !== 32'h6) begin failures++; $display("FAIL single_stat_popped: got %h expected %h", d, 32'h6); end
        wait_until(n0 + 40);
        rd(STAT, d);
        checks++;
        if (d !== 32'h6) begin failures++; $display("FAIL single_busy_last: got %h expected %h", d, 32'h6); end
        wait_until(n0 + 41);
        rd(STAT, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL single_busy_drop: got %h expected %h", d, 32'h2); end
        expq.delete();
        add_bits(1'b1, 1);
        add_frame(8'hA5, 3);
        add_bits(1'b1, 4);
        wait_until(n0 + expq.size());
        for (int j = 0; j < expq.size(); j++) begin
            checks++;
            if (txlog[n0+j] !== expq[j]) begin
                failures++;
                $display("FAIL single_wave: tx=%b at +%0d expected %b", txlog[n0+j], j, expq[j]);
                break;
            end
        end
    endtask

    task automatic test_back_to_back;
        int n0, t;
        logic [31:0] d;
        logic [7:0]  b [3];
        logic [31:0] exp_stat [4];
        b = '{8'h55, 8'h0F, 8'hF0};
        exp_stat = '{32'h24, 32'h14, 32'h06, 32'h02};
        store(TXD, rnd_hi(b[0]), n0);
        store(TXD, rnd_hi(b[1]), t);
        store(TXD, rnd_hi(b[2]), t);
        for (int k = 0; k < 4; k++) begin
            wait_until(n0 + 2 + (k == 0 ? 0 : 40 * k - 1));
            rd(STAT, d);
            checks++;
            if (d !== exp_stat[k]) begin failures++; $display("FAIL b2b_stat%0d: got %h expected %h", k, d, exp_stat[k]); end
        end
        expq.delete();
        add_bits(1'b1, 1);
        for (int k = 0; k < 3; k++) add_frame(b[k], 3);
        add_bits(1'b1, 4);
        wait_until(n0 + expq.size());
        for (int j = 0; j < expq.size(); j++) begin
            checks++;
            if (txlog[n0+j] !== expq[j]) begin
                failures++;
                $display("FAIL b2b_wave: tx=%b at +%0d expected %b", txlog[n0+j], j, expq[j]);
                break;
            end
        end
    endtask

    task automatic test_overflow;
        int n0, t;
        logic [31:0] d;
        logic [7:0]  b [6];
        logic [7:0]  x;
        for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
        x = 8'($urandom);
        store(TXD, rnd_hi(b[0]), n0);
        for (int k = 1; k < 6; k++) store(TXD, rnd_hi(b[k]), t);
        // The idle FSM drains b[0] on the next edge; four more fill the FIFO, b[5] is dropped.
        rd(STAT, d);
        checks++;
        if (d !== 32'h4D) begin failures++; $display("FAIL ovf_set: got %h expected %h", d, 32'h4D); end
        store(STAT, 32'hFFFF_FFF7, t);
        rd(STAT, d);
        checks++;
        if (d !== 32'h4D) begin failures++; $display("FAIL ovf_keep: got %h expected %h", d, 32'h4D); end
        store(STAT, 32'h8, t);
        rd(STAT, d);
        checks++;
        if (d !== 32'h45) begin failures++; $display("FAIL ovf_clear: got %h expected %h", d, 32'h45); end
        wait_until(n0 + 40);
        store(TXD, rnd_hi(x), t);
        rd(STAT, d);
        checks++;
        if (d !== 32'h45) begin failures++; $display("FAIL full_pop_push: got %h expected %h", d, 32'h45); end
        expq.delete();
        add_bits(1'b1, 1);
        for (int k = 0; k < 5; k++) add_frame(b[k], 3);
        add_frame(x, 3);
        add_bits(1'b1, 4);
        wait_until(n0 + expq.size());
        for (int j = 0; j < expq.size(); j++) begin
            checks++;
            if (txlog[n0+j] !== expq[j]) begin
                failures++;
                $display("FAIL ovf_wave: tx=%b at +%0d expected %b", txlog[n0+j], j, expq[j]);
                break;
            end
        end
        rd(STAT, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL ovf_drained: got %h expected %h", d, 32'h2); end
    endtask

    task automatic test_baud_change;
        int n0, t;
        logic [31:0] d;
        logic [7:0]  b;
        b = 8'($urandom);
        store(BAUD, 32'h7, t);
        store(TXD, rnd_hi(b), n0);
        wait_until(n0 + 3);
        store(BAUD, 32'h0, t);
        rd(BAUD, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL baud_read: got %h expected 0", d); end
        expq.delete();
        add_bits(1'b1, 1);
        add_bits(1'b0, 8);
        for (int i = 0; i < 8; i++) add_bits(b[i], 1);
        add_bits(1'b1, 5);
        wait_until(n0 + expq.size());
        for (int j = 0; j < expq.size(); j++) begin
            checks++;
            if (txlog[n0+j] !== expq[j]) begin
                failures++;
                $display("FAIL baud_wave: tx=%b at +%0d expected %b", txlog[n0+j], j, expq[j]);
                break;
            end
        end
        store(BAUD, 32'h3, t);
    endtask

    task automatic test_decode;
        int n0, t;
        logic [31:0] d;
        rd(RSVD, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL dec_rsvd: got %h expected 0", d); end
        rd(BASE - 32'h4, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL dec_below: got %h expected 0", d); end
        rd(BASE + 32'h14, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL dec_above: got %h expected 0", d); end
        store(BASE + 32'h10, 32'hAB, n0);
        rd(STAT, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL dec_nopush: got %h expected %h", d, 32'h2); end
        store(BASE + 32'h18, 32'h0, t);
        store(RSVD, 32'h5A, t);
        rd(BAUD, d);
        checks++;
        if (d !== 32'h3) begin failures++; $display("FAIL dec_baud_kept: got %h expected %h", d, 32'h3); end
        rd(STAT + 32'h3, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL dec_lowbits: got %h expected %h", d, 32'h2); end
        wait_until(n0 + 10);
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (txlog[n0+j] !== 1'b1) begin
                failures++;
                $display("FAIL dec_idle: tx=%b at +%0d expected 1", txlog[n0+j], j);
                break;
            end
        end
    endtask

    task automatic test_random;
        int n0, t, div, n;
        logic [7:0] b [4];
        for (int it = 0; it < 6; it++) begin
            div = $urandom_range(0, 3);
            n   = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
            store(BAUD, 32'(div), t);
            store(TXD, rnd_hi(b[0]), n0);
            for (int k = 1; k < n; k++) store(TXD, rnd_hi(b[k]), t);
            expq.delete();
            add_bits(1'b1, 1);
            for (int k = 0; k < n; k++) add_frame(b[k], div);
            add_bits(1'b1, 4);
            wait_until(n0 + expq.size());
            for (int j = 0; j < expq.size(); j++) begin
                checks++;
                if (txlog[n0+j] !== expq[j]) begin
                    failures++;
                    $display("FAIL rand_wave it%0d div%0d n%0d: tx=%b at +%0d expected %b",
                             it, div, n, txlog[n0+j], j, expq[j]);
                    break;
                end
            end
        end
        store(BAUD, 32'h3, t);
    endtask

    task automatic test_reset_midframe;
        int n0, t, m;
        logic [31:0] d;
        store(BAUD, 32'h5, t);
        store(TXD, 32'h0, n0);
        wait_until(n0 + 20);
        checks++;
        if (tx !== 1'b0) begin failures++; $display("FAIL mid_frame_low: tx=%b expected 0", tx); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL mid_reset_tx: tx=%b expected 1", tx); end
        rd(STAT, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL mid_reset_status: got %h expected %h", d, 32'h2); end
        rd(BAUD, d);
        checks++;
        if (d !== 32'h3) begin failures++; $display("FAIL mid_reset_baud: got %h expected %h", d, 32'h3); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        m = cyc;
        wait_until(m + 20);
        for (int j = 0; j < 20; j++) begin
            checks++;
            if (txlog[m+j] !== 1'b1) begin
                failures++;
                $display("FAIL post_reset_idle: tx=%b at +%0d expected 1", txlog[m+j], j);
                break;
            end
        end
        rd(STAT, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL post_reset_status: got %h expected %h", d, 32'h2); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_baud_change();
        test_decode();
        test_random();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
